// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, instruction-memory write port and boot status out
//   in_data/in_valid/in_ready  byte stream handshake
//   mem_addr/mem_wdata/mem_wr  instruction memory write port
//   cpu_reset/load_done/load_error  boot status
//   master = stream source and memory/status sink, slave = loader
interface program_loader_if #(parameter int ADDR_W = 32);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_wr;
   logic              cpu_reset;
   logic              load_done;
   logic              load_error;
   modport master (output in_data, in_valid,
                   input in_ready, mem_addr, mem_wdata, mem_wr, cpu_reset, load_done, load_error);
   modport slave  (input in_data, in_valid,
                   output in_ready, mem_addr, mem_wdata, mem_wr, cpu_reset, load_done, load_error);
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles a length-prefixed, XOR-checksummed byte stream into 32-bit words
//   Clk, Reset  clock and asynchronous active-high reset
//   bus         stream handshake, memory write port and boot status (slave side)
module program_loader #(
   parameter int MEM_WORDS = 4096,
   parameter int ADDR_W    = 32
) (
   input logic           Clk,
   input logic           Reset,
   program_loader_if.slave bus
);
   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR} state_t;
   state_t            state, nxt;
   logic [15:0]       len;
   logic [16:0]       widx;
   logic [1:0]        bidx;
   logic [7:0]        csum;
   logic [31:0]       word;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_wr;
   logic              ready;
   logic              accept;
   logic [15:0]       n_new;
   assign ready  = !Reset && (state == S_LEN0 || state == S_LEN1 || state == S_DATA || state == S_CSUM);
   assign accept = bus.in_valid && ready;
   assign n_new  = {bus.in_data, len[7:0]};
   always_comb begin
      nxt = state;
      case (state)
         S_LEN0:  nxt = accept ? S_LEN1 : S_LEN0;
         S_LEN1:  nxt = !accept ? S_LEN1 :
                        n_new == 16'd0 ? S_CSUM :
                        32'(n_new) > 32'(MEM_WORDS) ? S_ERR : S_DATA;
         S_DATA:  nxt = accept && bidx == 2'd3 ? S_WRITE : S_DATA;
         S_WRITE: nxt = widx + 17'd1 == {1'b0, len} ? S_CSUM : S_DATA;
         S_CSUM:  nxt = !accept ? S_CSUM : bus.in_data == csum ? S_DONE : S_ERR;
         default: nxt = state;
      endcase
   end
   // The write strobe, address and word are registered on the edge that takes
   // lane 3, so they are valid exactly during S_WRITE and hold afterwards.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_LEN0;
         len       <= '0;
         widx      <= '0;
         bidx      <= '0;
         csum      <= '0;
         word      <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wr    <= 1'b0;
      end else begin
         state  <= nxt;
         mem_wr <= 1'b0;
         if (accept && state == S_LEN0) len[7:0] <= bus.in_data;
         if (accept && state == S_LEN1) begin
            len[15:8] <= bus.in_data;
            widx      <= '0;
            bidx      <= '0;
         end
         if (accept && state == S_DATA) begin
            csum <= csum ^ bus.in_data;
            bidx <= bidx + 2'd1;
            word <= {bus.in_data, word[31:8]};
            if (bidx == 2'd3) begin
               mem_wr    <= 1'b1;
               mem_wdata <= {bus.in_data, word[31:8]};
               mem_addr  <= ADDR_W'({widx, 2'b00});
            end
         end
         if (state == S_WRITE) widx <= widx + 17'd1;
      end
   end
   assign bus.in_ready   = ready;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.mem_wr     = mem_wr;
   assign bus.cpu_reset  = Reset || state != S_DONE;
   assign bus.load_done  = state == S_DONE;
   assign bus.load_error = state == S_ERR;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of the program loader with MEM_WORDS = 4
module tb_program_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   bad_ready = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int   base;
   int   cyc;
   program_loader_if #(.ADDR_W(32)) bus ();
   program_loader #(.MEM_WORDS(4), .ADDR_W(32)) dut (.Clk(clk), .Reset(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.mem_wr) begin
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_wdata);
         if (bus.in_ready) bad_ready++;
      end
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Offers one byte after 'gap' idle cycles; returns edges spent offering it.
   task automatic send(input logic [7:0] b, input int gap, output int n);
      logic r;
      bus.in_valid = 1'b0;
      repeat (gap) begin
         bus.in_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      r = 1'b0;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         r = bus.in_ready;
         @(posedge clk);
         #1;
         if (r) break;
      end
      if (!r) check("send_timeout", 1, 0);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask
   task automatic send_list(input logic [7:0] bytes[$], input int maxgap);
      int n;
      foreach (bytes[i]) send(bytes[i], $urandom_range(0, maxgap), n);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu_reset", bus.cpu_reset, 1);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_done", bus.load_done, 0);
      check("rst_error", bus.load_error, 0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", bus.in_ready, 1);
      base = wa.size();
   endtask
   initial begin
      int n;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #1;
      check("init_in_ready", bus.in_ready, 0);
      check("init_cpu_reset", bus.cpu_reset, 1);
      check("init_mem_wr", bus.mem_wr, 0);
      check("init_mem_addr", bus.mem_addr, 0);
      check("init_mem_wdata", bus.mem_wdata, 0);
      @(posedge clk);
      #1;
      do_reset();
      // one-word load, back-to-back bytes
      send_list('{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0}, 0);
      send(8'h00, 0, n);
      check("w1_mem_wr", bus.mem_wr, 1);
      check("w1_ready_low", bus.in_ready, 0);
      send(8'hB6, 0, n);
      check("w1_csum_latency", n, 2);
      check("w1_done", bus.load_done, 1);
      check("w1_cpu_reset", bus.cpu_reset, 0);
      check("w1_nwrites", wa.size() - base, 1);
      if (wa.size() - base == 1) begin
         check("w1_addr", wa[base], 32'h0);
         check("w1_data", wd[base], 32'h00A00513);
      end
      bus.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("w1_done_ready", bus.in_ready, 0);
      check("w1_done_sticky", bus.load_done, 1);
      // zero-length image
      do_reset();
      send_list('{8'h00, 8'h00, 8'h00}, 1);
      check("z_done", bus.load_done, 1);
      check("z_cpu_reset", bus.cpu_reset, 0);
      check("z_nwrites", wa.size() - base, 0);
      // bad checksum
      do_reset();
      send_list('{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7}, 0);
      check("bad_error", bus.load_error, 1);
      check("bad_done", bus.load_done, 0);
      check("bad_cpu_reset", bus.cpu_reset, 1);
      check("bad_nwrites", wa.size() - base, 1);
      if (wa.size() - base == 1) check("bad_addr", wa[base], 32'h0);
      repeat (5) @(posedge clk);
      #1;
      check("bad_ready_stays_low", bus.in_ready, 0);
      // oversize (N = 5 > 4)
      do_reset();
      send_list('{8'h05, 8'h00}, 0);
      check("big_error", bus.load_error, 1);
      check("big_ready", bus.in_ready, 0);
      check("big_cpu_reset", bus.cpu_reset, 1);
      check("big_nwrites", wa.size() - base, 0);
      // N == MEM_WORDS is accepted
      do_reset();
      send_list('{8'h04, 8'h00}, 0);
      check("max_no_error", bus.load_error, 0);
      check("max_ready", bus.in_ready, 1);
      // three words with random valid gaps
      do_reset();
      send_list('{8'h03, 8'h00,
                  8'h01, 8'h02, 8'h03, 8'h04,
                  8'h10, 8'h20, 8'h30, 8'h40,
                  8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44}, 3);
      check("w3_done", bus.load_done, 1);
      check("w3_nwrites", wa.size() - base, 3);
      if (wa.size() - base == 3) begin
         check("w3_addr0", wa[base], 32'h0);
         check("w3_data0", wd[base], 32'h04030201);
         check("w3_addr1", wa[base+1], 32'h4);
         check("w3_data1", wd[base+1], 32'h40302010);
         check("w3_addr2", wa[base+2], 32'h8);
         check("w3_data2", wd[base+2], 32'hDDCCBBAA);
      end
      check("ready_during_write", bad_ready, 0);
      // reset mid-load, then a fresh image
      do_reset();
      send_list('{8'h02, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16}, 0);
      check("mid_not_done", bus.load_done, 0);
      rst = 1'b1;
      #1;
      check("mid_cpu_reset", bus.cpu_reset, 1);
      check("mid_ready", bus.in_ready, 0);
      do_reset();
      send_list('{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6}, 2);
      check("mid_done", bus.load_done, 1);
      check("mid_nwrites", wa.size() - base, 1);
      if (wa.size() - base == 1) begin
         check("mid_addr", wa[base], 32'h0);
         check("mid_data", wd[base], 32'h00A00513);
      end
      cyc = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
